// File: rtl/clk_div_period_monitor_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// clk_div_period_monitor_pkg : FSM encodings and tolerance helper for clock monitors
// Rev 1.0
// ----------------------------------------------------------------------------
package clk_div_period_monitor_pkg;

  localparam int unsigned STATE_W = 2;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_RISE = 2'd1;
  localparam logic [1:0] ST_MEASURE   = 2'd2;

  // Unsigned distance compare; never wraps around zero.
  function automatic logic within_tol(input logic [31:0] meas,
                                      input logic [31:0] expv,
                                      input logic [31:0] tol);
    logic [31:0] diff;
    diff = (meas >= expv) ? (meas - expv) : (expv - meas);
    return (diff <= tol);
  endfunction

endpackage
`default_nettype wire

// File: rtl/clk_edge_detect.sv
`default_nettype none
// ----------------------------------------------------------------------------
// clk_edge_detect : two-stage sampler of a same-domain clock-like signal, rise pulse
// Rev 1.0
// ----------------------------------------------------------------------------
module clk_edge_detect (
  input  logic clk,
  input  logic resetn,
  input  logic i_sig,
  output logic o_level,
  output logic o_rise
);

  logic s0_q, s0_d;
  logic s1_q, s1_d;

  always_comb begin
    s0_d = i_sig;
    s1_d = s0_q;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      s0_q <= 1'b0;
      s1_q <= 1'b0;
    end else begin
      s0_q <= s0_d;
      s1_q <= s1_d;
    end
  end

  assign o_level = s0_q;
  assign o_rise  = s0_q & ~s1_q;

endmodule
`default_nettype wire

// File: rtl/clk_div_period_monitor.sv
`default_nettype none
// ----------------------------------------------------------------------------
// clk_div_period_monitor : measures period/high time of a divided clock, lock and sticky error
// Rev 1.0
// ----------------------------------------------------------------------------
module clk_div_period_monitor
  import clk_div_period_monitor_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned EXP_PERIOD = 7,
  parameter int unsigned EXP_HIGH   = 3,
  parameter int unsigned TOL        = 0,
  parameter int unsigned LOCK_CNT   = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_enable,
  input  logic             i_div_clk,
  input  logic             i_clr_err,
  output logic [WIDTH-1:0] o_period,
  output logic [WIDTH-1:0] o_high,
  output logic             o_valid,
  output logic             o_locked,
  output logic             o_err
);

  localparam int unsigned      LCW      = $clog2(LOCK_CNT + 1);
  localparam logic [LCW-1:0]   LOCK_MAX = LCW'(LOCK_CNT);

  logic s0, rise;

  clk_edge_detect u_edge (
    .clk     (clk),
    .resetn  (resetn),
    .i_sig   (i_div_clk),
    .o_level (s0),
    .o_rise  (rise)
  );

  logic [STATE_W-1:0] state_q, state_d;
  logic [WIDTH-1:0]   per_cnt_q, per_cnt_d;
  logic [WIDTH-1:0]   hi_cnt_q, hi_cnt_d;
  logic [WIDTH-1:0]   period_q, period_d;
  logic [WIDTH-1:0]   high_q, high_d;
  logic [LCW-1:0]     lock_cnt_q, lock_cnt_d;
  logic               valid_q, valid_d;
  logic               locked_q, locked_d;
  logic               err_q, err_d;
  logic               err_set;
  logic               in_spec;
  logic               timeout;

  assign in_spec = within_tol(32'(per_cnt_q), EXP_PERIOD, TOL) &&
                   within_tol(32'(hi_cnt_q), EXP_HIGH, TOL);
  assign timeout = (per_cnt_q == '1) && !rise;

  always_comb begin
    state_d    = state_q;
    per_cnt_d  = per_cnt_q;
    hi_cnt_d   = hi_cnt_q;
    period_d   = period_q;
    high_d     = high_q;
    lock_cnt_d = lock_cnt_q;
    locked_d   = locked_q;
    valid_d    = 1'b0;
    err_set    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_enable) state_d = ST_WAIT_RISE;
      end
      ST_WAIT_RISE: begin
        if (rise) begin
          per_cnt_d = WIDTH'(1);
          hi_cnt_d  = WIDTH'(s0);
          state_d   = ST_MEASURE;
        end
      end
      ST_MEASURE: begin
        if (rise) begin
          period_d  = per_cnt_q;
          high_d    = hi_cnt_q;
          valid_d   = 1'b1;
          per_cnt_d = WIDTH'(1);
          hi_cnt_d  = WIDTH'(s0);
          if (in_spec) begin
            if (lock_cnt_q != LOCK_MAX) lock_cnt_d = lock_cnt_q + LCW'(1);
            if (lock_cnt_d == LOCK_MAX) locked_d = 1'b1;
          end else begin
            lock_cnt_d = '0;
            locked_d   = 1'b0;
            err_set    = 1'b1;
          end
        end else if (timeout) begin
          // Input stuck high or low: abandon this period and re-arm on the next rise.
          err_set    = 1'b1;
          locked_d   = 1'b0;
          lock_cnt_d = '0;
          state_d    = ST_WAIT_RISE;
        end else begin
          per_cnt_d = per_cnt_q + WIDTH'(1);
          hi_cnt_d  = hi_cnt_q + WIDTH'(s0);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Disable overrides any event of this cycle; error and last results survive.
    if (!i_enable) begin
      state_d    = ST_IDLE;
      per_cnt_d  = '0;
      hi_cnt_d   = '0;
      lock_cnt_d = '0;
      locked_d   = 1'b0;
      valid_d    = 1'b0;
      period_d   = period_q;
      high_d     = high_q;
      err_set    = 1'b0;
    end

    err_d = err_q;
    if (i_clr_err) err_d = 1'b0;
    if (err_set)   err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      per_cnt_q  <= '0;
      hi_cnt_q   <= '0;
      period_q   <= '0;
      high_q     <= '0;
      lock_cnt_q <= '0;
      valid_q    <= 1'b0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      per_cnt_q  <= per_cnt_d;
      hi_cnt_q   <= hi_cnt_d;
      period_q   <= period_d;
      high_q     <= high_d;
      lock_cnt_q <= lock_cnt_d;
      valid_q    <= valid_d;
      locked_q   <= locked_d;
      err_q      <= err_d;
    end
  end

  assign o_period = period_q;
  assign o_high   = high_q;
  assign o_valid  = valid_q;
  assign o_locked = locked_q;
  assign o_err    = err_q;

endmodule
`default_nettype wire
